// File: rtl/ser_link_pkg.sv
// Shared types and bit-level constants for the framed serial link.
// Frame: start(0), WIDTH data bits LSB first, optional even parity, stop(1).
package ser_link_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   localparam logic BIT_IDLE  = 1'b1;
   localparam logic BIT_START = 1'b0;
   localparam logic BIT_STOP  = 1'b1;

   function automatic int frame_len(input int width, input int parity_en);
      return width + 2 + ((parity_en != 0) ? 1 : 0);
   endfunction

endpackage

// File: rtl/ser_rx.sv
// Deserialiser: samples one bit per clock, delivers the word at the stop sample.
// No back-pressure: rx_valid/error flags are one-cycle pulses the consumer must catch.
module ser_rx
   import ser_link_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_parity_err,
   output logic             rx_frame_err
);

   localparam int CNT_W = $clog2(WIDTH);

   rx_state_t        state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             par_rx;
   logic             last_bit;

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:      if (ser_in == BIT_START) state_nxt = RX_DATA;
         RX_DATA:      if (last_bit) state_nxt = PARITY_EN ? RX_PARITY : RX_STOP;
         RX_PARITY:    state_nxt = RX_STOP;
         RX_STOP:      state_nxt = (ser_in == BIT_STOP) ? RX_IDLE : RX_WAIT_IDLE;
         RX_WAIT_IDLE: if (ser_in == BIT_IDLE) state_nxt = RX_IDLE;
         default:      state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg         <= '0;
         cnt           <= '0;
         par_rx        <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         case (state)
            RX_DATA: begin
               shreg <= {ser_in, shreg[WIDTH-1:1]};
               cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
            end
            RX_PARITY: par_rx <= ser_in;
            RX_STOP: begin
               // a parity mismatch still delivers the word; a bad stop bit does not
               if (ser_in == BIT_STOP) begin
                  rx_data       <= shreg;
                  rx_valid      <= 1'b1;
                  rx_parity_err <= PARITY_EN && (par_rx != ^shreg);
               end else begin
                  rx_frame_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ser_tx.sv
// Serialiser: one frame bit per clock, word captured at accept.
// Latency: start bit on the line the cycle after accept; ready only while idle.
module ser_tx
   import ser_link_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             ser_out
);

   localparam int CNT_W = $clog2(WIDTH);

   tx_state_t        state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             par_bit;
   logic             last_bit;
   logic             accept;

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign accept   = tx_valid && tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= TX_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      case (state)
         TX_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) state_nxt = TX_START;
         end
         TX_START:  state_nxt = TX_DATA;
         TX_DATA:   if (last_bit) state_nxt = PARITY_EN ? TX_PARITY : TX_STOP;
         TX_PARITY: state_nxt = TX_STOP;
         TX_STOP:   state_nxt = TX_IDLE;
         default:   state_nxt = TX_IDLE;
      endcase
   end

   // ser_out is registered: each state drives the bit that follows it on the line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         cnt     <= '0;
         par_bit <= 1'b0;
         ser_out <= BIT_IDLE;
      end else begin
         case (state)
            TX_IDLE: begin
               if (accept) begin
                  shreg   <= tx_data;
                  par_bit <= ^tx_data;
                  ser_out <= BIT_START;
               end
            end
            TX_START: begin
               ser_out <= shreg[0];
               shreg   <= shreg >> 1;
               cnt     <= '0;
            end
            TX_DATA: begin
               if (last_bit) begin
                  ser_out <= PARITY_EN ? par_bit : BIT_STOP;
                  cnt     <= '0;
               end else begin
                  ser_out <= shreg[0];
                  shreg   <= shreg >> 1;
                  cnt     <= cnt + CNT_W'(1);
               end
            end
            TX_PARITY: ser_out <= BIT_STOP;
            TX_STOP:   ser_out <= BIT_IDLE;
            default:   ser_out <= BIT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ser_link.sv
// Framed serial link top: independent transmitter and receiver on one clock.
// Link latency is frame_len cycles when ser_out is looped to ser_in externally.
module ser_link
   import ser_link_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             ser_out,
   input  logic             ser_in,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_parity_err,
   output logic             rx_frame_err
);

   ser_tx #(
      .WIDTH     (WIDTH),
      .PARITY_EN (PARITY_EN)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .ser_out  (ser_out)
   );

   ser_rx #(
      .WIDTH     (WIDTH),
      .PARITY_EN (PARITY_EN)
   ) u_rx (
      .clk           (clk),
      .rst           (rst),
      .ser_in        (ser_in),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err)
   );

endmodule

// File: doc/ser_link.md
# ser_link

Parametrised, framed, handshaked serial link: a transmitter that serialises a WIDTH-bit word onto one wire and a receiver that rebuilds it. It succeeds the free-running counter/mux serial pair. It adds start/stop framing, optional even parity, valid/ready flow control on the transmit side, and error reporting on the receive side. Both halves run on one clock. The serial wires are top-level ports so the bench, or a board, can close the loop.

## Interface
Parameters:
- WIDTH, 16, data word width (≥2)
- PARITY_EN, 1, 1 = append even-parity bit, 0 = no parity bit

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- tx_valid  in  1  word on tx_data offered
- tx_ready  out  1  transmitter can accept a word
- tx_data  in  WIDTH  word to send, captured at accept
- ser_out  out  1  serial line out (idle = 1)
- ser_in  in  1  serial line in (idle = 1)
- rx_valid  out  1  one-cycle pulse, rx_data holds a received word
- rx_data  out  WIDTH  last received word
- rx_parity_err  out  1  pulses with rx_valid when parity mismatched (0 if PARITY_EN=0)
- rx_frame_err  out  1  one-cycle pulse on bad stop bit

## Operation
- Frame format: start bit 0, then WIDTH data bits LSB first, then parity bit (even: ^data) if PARITY_EN, then stop bit 1. One bit per clock. Frame length F = WIDTH + 2 + PARITY_EN.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE.
  - Accept = tx_valid & tx_ready at an edge. At accept: latch tx_data, ser_out <= 0, go to START.
  - START → DATA. DATA shifts out WIDTH bits and then goes to PARITY, or to STOP if PARITY_EN=0. PARITY → STOP. STOP → IDLE with ser_out = 1.
  - tx_data changes after accept are ignored. tx_valid while busy has no effect.
- RX FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: ser_in sampled 0 → DATA.
  - DATA: shift WIDTH bits into a shadow register.
  - At the stop sample with ser_in = 1: load rx_data, pulse rx_valid, pulse rx_parity_err if parity mismatched (data is still delivered), go to IDLE.
  - At the stop sample with ser_in = 0: pulse rx_frame_err, leave rx_data unchanged, no rx_valid, go to WAIT_IDLE.
  - WAIT_IDLE: stay until ser_in = 1, then go to IDLE.
- rx has no back-pressure. The consumer must take rx_data on the rx_valid cycle. rx_data is stable until the next good frame.

## Timing
- Reset values (asynchronous): ser_out = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, rx_parity_err = 0, rx_frame_err = 0. Both FSMs go to IDLE and the bit counters go to 0.
- Cycle numbering assumes an accept at edge k and ser_out looped to ser_in:
  - Start bit is on the line after edge k.
  - Data bit i is on the line after edge k+1+i.
  - Parity bit is on the line after edge k+1+WIDTH.
  - Stop bit is on the line after edge k+F−1.
  - tx_ready returns to 1 after edge k+F.
  - Earliest next accept is at edge k+F+1, so the minimum frame period is F+1 (one idle bit).
- RX samples on the edge after each TX bit:
  - Start bit at edge k+1; data bit i at edge k+2+i; stop bit at edge k+F.
  - rx_valid is high for exactly the cycle after edge k+F. Link latency is F cycles (19 for the defaults).
- Error pulses are one cycle, aligned to the stop-sample edge.
- Reset mid-frame: outputs return to reset values immediately, the partial word is discarded, and no rx_valid is issued.
- Bit counter width is $clog2(WIDTH). It runs 0..WIDTH−1, is cleared on leaving DATA, and never wraps within a frame.

## Structure
- Package ser_link_pkg holds:
  - tx_state_t and rx_state_t enums
  - a function frame_len(WIDTH, PARITY_EN)
  - the idle/start/stop bit-level constants
- Sub-modules:
  - ser_tx: TX FSM, shift register, parity generator
  - ser_rx: RX FSM, shift register, parity checker, error flags
  - ser_link instantiates one of each. It does no internal loopback.

## Test plan
- Reset: assert rst at any point → ser_out = 1, tx_ready = 1, rx_valid = 0, rx_data = 16'h0000, both error outputs 0.
- Loopback, defaults: send 16'hA5C3, accepted at edge k → ser_out shows 0, then the bits LSB first, parity 0, stop 1. rx_valid is high only after edge k+19, with rx_data = 16'hA5C3 and rx_parity_err = 0.
- Back-to-back: tx_valid held with 16'h0001 then 16'hFFFF → tx_ready low for 19 cycles, second accept exactly 20 edges after the first, two rx_valid pulses 20 cycles apart with the correct data.
- Parity fault: bench inverts the parity bit on the line → rx_valid = 1 with rx_parity_err = 1 and rx_data = the sent word.
- Framing fault: bench forces the stop bit to 0 → rx_frame_err pulses and rx_valid stays 0. RX holds until ser_in = 1, then the next frame 16'h1234 is received correctly.
- Reset after data bit 5, then WIDTH=8, PARITY_EN=0 build: reset mid-frame → ser_out = 1 at once and no rx_valid. In the 8-bit build, sending 8'h3C → F = 10, rx_valid after edge k+10, rx_parity_err tied 0.
